// File: rtl/aes_clm_pkg.sv
// rtl/aes_clm_pkg.sv - shared types, Din slot layout and LFSR step for the CLM host controller
package aes_clm_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFRESH,
    S_RUN,
    S_GAP
  } state_t;

  localparam int RND_BASE   = 496;
  localparam int RND_STRIDE = 16;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Right-shifting Galois step; tap bit 0 is the implicit +1 term (the bit shifted out).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ ({32{s[0]}} & {LFSR_TAPS[31:1], 1'b0});
  endfunction

endpackage

// File: rtl/aes_clm_host_ctrl_if.sv
// rtl/aes_clm_host_ctrl_if.sv - request/acknowledge bus between the host controller and the masked AES core
interface aes_clm_host_ctrl_if #(
  parameter int D  = 8,
  parameter int NR = 23,
  parameter int PW = 5
);
  logic [127:0]    core_pt;
  logic [127:0]    core_key;
  logic [NR*D-1:0] core_rnd;
  logic [PW-1:0]   core_p;
  logic            core_req;
  logic            core_ack;
  logic [127:0]    core_ct;

  modport master (
    output core_pt, core_key, core_rnd, core_p, core_req,
    input  core_ack, core_ct
  );

  modport slave (
    input  core_pt, core_key, core_rnd, core_p, core_req,
    output core_ack, core_ct
  );
endinterface

// File: rtl/clm_lfsr32.sv
// rtl/clm_lfsr32.sv - 32-bit Galois LFSR randomness source with seed load; a zero seed is replaced by 1
module clm_lfsr32
  import aes_clm_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= 32'h0000_0001;
    end else if (EN) begin
      if (load) begin
        state <= (seed == 32'h0) ? 32'h0000_0001 : seed;
      end else if (step) begin
        state <= lfsr_step(state);
      end
    end
  end

endmodule

// File: rtl/aes_clm_host_ctrl.sv
// rtl/aes_clm_host_ctrl.sv - host-side controller: latches key/data/randomness, drives the masked core,
// chains batch encryptions, refreshes randomness from the LFSR and aborts on watchdog expiry
module aes_clm_host_ctrl
  import aes_clm_pkg::*;
#(
  parameter int D       = 8,
  parameter int NR      = 23,
  parameter int PW      = 5,
  parameter int BW      = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          EN,
  input  logic [127:0]  Kin,
  input  logic          Krdy,
  input  logic [511:0]  Din,
  input  logic          Drdy,
  input  logic          MODE_LFSR,
  input  logic [BW-1:0] BATCH,
  output logic [127:0]  Dout,
  output logic          Kvld,
  output logic          Dvld,
  output logic          BSY,
  output logic          ERR,
  aes_clm_host_ctrl_if.master core
);

  localparam int WIW = (NR > 1) ? $clog2(NR) : 1;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WIW-1:0] WIDX_LAST = WIW'(NR - 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [127:0]    pt_q, key_q;
  logic [NR*D-1:0] rnd_q;
  logic [PW-1:0]   p_q;
  logic            mode_q;
  logic [BW-1:0]   cnt_q;
  logic [WIW-1:0]  widx_q;
  logic [WDW-1:0]  wdog_q;
  logic [31:0]     lfsr_q;
  logic [D-1:0]    rnd_word;
  logic            start;
  logic            unused_din;

  assign start      = (state == S_IDLE) && Drdy;
  assign rnd_word   = D'(lfsr_step(lfsr_q));
  assign unused_din = ^Din;

  clm_lfsr32 u_lfsr (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .EN    (EN),
    .load  (start && MODE_LFSR),
    .step  (state == S_REFRESH),
    .seed  (Din[RND_BASE-1 -: 32]),
    .state (lfsr_q)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_IDLE;
    end else if (EN) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (Drdy) state_nxt = MODE_LFSR ? S_REFRESH : S_RUN;
      S_REFRESH: if (widx_q == WIDX_LAST) state_nxt = S_RUN;
      S_RUN: begin
        // An ack in the expiry cycle still counts as a good result.
        if (core.core_ack)               state_nxt = (cnt_q == '0) ? S_IDLE : S_GAP;
        else if (wdog_q == WDOG_LAST)    state_nxt = S_IDLE;
      end
      S_GAP:     state_nxt = mode_q ? S_REFRESH : S_RUN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pt_q   <= '0;
      key_q  <= '0;
      rnd_q  <= '0;
      p_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
      widx_q <= '0;
      wdog_q <= '0;
      Dout   <= '0;
      Kvld   <= 1'b0;
      Dvld   <= 1'b0;
      ERR    <= 1'b0;
    end else if (EN) begin
      Kvld <= Krdy;
      Dvld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Krdy) key_q <= Kin;
          if (Drdy) begin
            pt_q   <= Din[127:0];
            p_q    <= Din[RND_BASE +: PW];
            mode_q <= MODE_LFSR;
            cnt_q  <= BATCH;
            ERR    <= 1'b0;
            widx_q <= '0;
            wdog_q <= '0;
            if (!MODE_LFSR) begin
              for (int i = 0; i < NR; i++) begin
                rnd_q[(NR-1-i)*D +: D] <= Din[RND_BASE-1-RND_STRIDE*i -: D];
              end
            end
          end
        end
        S_REFRESH: begin
          rnd_q[(NR-1-int'(widx_q))*D +: D] <= rnd_word;
          widx_q <= (widx_q == WIDX_LAST) ? '0 : widx_q + WIW'(1);
        end
        S_RUN: begin
          if (core.core_ack) begin
            wdog_q <= '0;
            if (cnt_q == '0) begin
              Dout <= core.core_ct;
              Dvld <= 1'b1;
            end else begin
              pt_q  <= core.core_ct;
              cnt_q <= cnt_q - BW'(1);
            end
          end else if (wdog_q == WDOG_LAST) begin
            wdog_q <= '0;
            ERR    <= 1'b1;
            Dout   <= '0;
            Dvld   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign BSY           = (state != S_IDLE);
  assign core.core_req = (state == S_RUN);
  assign core.core_pt  = pt_q;
  assign core.core_key = key_q;
  assign core.core_rnd = rnd_q;
  assign core.core_p   = p_q;

endmodule

// File: tb/tb_aes_clm_host_ctrl.sv
// tb/tb_aes_clm_host_ctrl.sv - directed self-checking bench for aes_clm_host_ctrl with a fixed-latency core model
module tb_aes_clm_host_ctrl;

  localparam int D  = 8;
  localparam int NR = 23;
  localparam int PW = 5;
  localparam int BW = 8;
  localparam int TO = 16;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT3 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic          CLK = 1'b0;
  logic          RSTn, EN, Krdy, Drdy, MODE_LFSR;
  logic [127:0]  Kin, Dout;
  logic [511:0]  Din;
  logic [BW-1:0] BATCH;
  logic          Kvld, Dvld, BSY, ERR;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rc      = 0;
  int   lat;
  logic ack_en;

  aes_clm_host_ctrl_if #(.D(D), .NR(NR), .PW(PW)) cif ();

  // Core model: acks in the L-th cycle of a request, returns pt+1.
  assign cif.core_ack = ack_en && cif.core_req && (rc == lat - 1);
  assign cif.core_ct  = cif.core_pt + 128'd1;

  always @(posedge CLK) if (EN) rc <= cif.core_req ? rc + 1 : 0;

  aes_clm_host_ctrl #(.D(D), .NR(NR), .PW(PW), .BW(BW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Kin(Kin), .Krdy(Krdy), .Din(Din), .Drdy(Drdy),
    .MODE_LFSR(MODE_LFSR), .BATCH(BATCH), .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld),
    .BSY(BSY), .ERR(ERR), .core(cif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mstep(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h80200002 : 32'h0);
  endfunction

  function automatic logic [511:0] mkdin(input logic [127:0] pt, input logic [7:0] wbase,
                                         input logic [4:0] pd, input logic [31:0] seed, input logic lf);
    logic [511:0] d;
    d = '0;
    d[127:0] = pt;
    for (int i = 0; i < NR; i++) d[495-16*i -: 8] = wbase + 8'(i);
    d[500:496] = pd;
    if (lf) d[495:464] = seed;
    return d;
  endfunction

  task automatic run_op(output int total, output int reqc, output int rises, output int busy_lo,
                        output logic [NR*D-1:0] rnd_first);
    logic prev;
    prev = 1'b0; reqc = 0; rises = 0; busy_lo = 0; rnd_first = '0;
    Drdy = 1'b1;
    tick();
    Drdy = 1'b0;
    total = 1;
    while (!Dvld && total < 400) begin
      if (cif.core_req) begin
        reqc++;
        if (!prev) begin
          rises++;
          if (rises == 1) rnd_first = cif.core_rnd;
        end
      end else if (BSY) begin
        busy_lo++;
      end
      prev = cif.core_req;
      tick();
      total++;
    end
    chk("dvld_seen", Dvld, 1'b1);
  endtask

  int               tot, reqc, rises, blo, n, seen;
  logic [NR*D-1:0]  rf, exp_rnd;
  logic [31:0]      s;

  initial begin
    RSTn = 1'b0; EN = 1'b1; Krdy = 1'b0; Drdy = 1'b0; MODE_LFSR = 1'b0;
    BATCH = '0; Kin = '0; Din = '0; ack_en = 1'b1; lat = 5;
    tick(); tick();
    chk("rst_dout", Dout, 0);
    chk("rst_dvld", Dvld, 0);
    chk("rst_bsy",  BSY, 0);
    chk("rst_err",  ERR, 0);
    chk("rst_kvld", Kvld, 0);
    chk("rst_req",  cif.core_req, 0);
    chk("rst_rnd",  cif.core_rnd, 0);
    RSTn = 1'b1;
    tick();

    Kin = K1; Krdy = 1'b1;
    tick();
    Krdy = 1'b0;
    chk("key_kvld", Kvld, 1);
    chk("key_load", cif.core_key, K1);
    tick();
    chk("key_kvld_drop", Kvld, 0);

    // Host mode, single shot
    Din = mkdin(PT1, 8'hA5, 5'h13, 32'h0, 1'b0); MODE_LFSR = 1'b0; BATCH = 0;
    run_op(tot, reqc, rises, blo, rf);
    chk("h_lat",  tot, 6);
    chk("h_req",  reqc, 5);
    chk("h_w0",   rf[NR*D-1 -: 8], 8'hA5);
    chk("h_w22",  rf[7:0], 8'hBB);
    chk("h_p",    cif.core_p, 5'h13);
    chk("h_dout", Dout, PT1 + 128'd1);
    chk("h_bsy",  BSY, 0);
    tick();
    chk("h_dvld_pulse", Dvld, 0);
    chk("h_bsy_after",  BSY, 0);

    // Batch chaining
    Din = mkdin(128'h0, 8'h10, 5'h0, 32'h0, 1'b0); BATCH = 2;
    run_op(tot, reqc, rises, blo, rf);
    chk("b_dout",  Dout, 3);
    chk("b_lat",   tot, 18);
    chk("b_req",   reqc, 15);
    chk("b_rises", rises, 3);
    chk("b_gaps",  blo, 2);

    // LFSR mode, zero seed, two iterations
    Din = mkdin(128'h55, 8'h00, 5'h01, 32'h0, 1'b1); MODE_LFSR = 1'b1; BATCH = 1;
    run_op(tot, reqc, rises, blo, rf);
    s = 32'h1; exp_rnd = '0;
    for (int i = 0; i < NR; i++) begin s = mstep(s); exp_rnd[(NR-1-i)*8 +: 8] = s[7:0]; end
    chk("l_w0",   rf[NR*D-1 -: 8], 8'h02);
    chk("l_rnd1", rf, exp_rnd);
    for (int i = 0; i < NR; i++) begin s = mstep(s); exp_rnd[(NR-1-i)*8 +: 8] = s[7:0]; end
    chk("l_rnd2", cif.core_rnd, exp_rnd);
    chk("l_lat",  tot, 58);
    chk("l_refresh_cycles", blo, 47);
    chk("l_dout", Dout, 128'h57);

    // Watchdog timeout, then ERR cleared by the next operation
    MODE_LFSR = 1'b0; BATCH = 0; ack_en = 1'b0;
    Din = mkdin(PT1, 8'h20, 5'h0, 32'h0, 1'b0);
    run_op(tot, reqc, rises, blo, rf);
    chk("t_lat",  tot, 17);
    chk("t_req",  reqc, 16);
    chk("t_dout", Dout, 0);
    chk("t_err",  ERR, 1);
    ack_en = 1'b1;
    run_op(tot, reqc, rises, blo, rf);
    chk("t_err_clr", ERR, 0);
    chk("t2_dout",   Dout, PT1 + 128'd1);

    // Drdy and Krdy during RUN are ignored except for Kvld
    lat = 8;
    Din = mkdin(PT2, 8'h30, 5'h0, 32'h0, 1'b0);
    Drdy = 1'b1; tick(); Drdy = 1'b0; tick();
    Din = mkdin(PT3, 8'h40, 5'h0, 32'h0, 1'b0);
    Drdy = 1'b1; Krdy = 1'b1; Kin = K2;
    tick();
    Drdy = 1'b0; Krdy = 1'b0;
    chk("r_kvld", Kvld, 1);
    chk("r_key",  cif.core_key, K1);
    chk("r_pt",   cif.core_pt, PT2);
    chk("r_req",  cif.core_req, 1);
    n = 3;
    while (!Dvld && n < 100) begin tick(); n++; end
    chk("r_lat",  n, 9);
    chk("r_dout", Dout, PT2 + 128'd1);
    tick();
    chk("r_no_restart", BSY, 0);

    // EN low freezes the operation and a pending Dvld
    lat = 5;
    Din = mkdin(PT1, 8'h50, 5'h0, 32'h0, 1'b0);
    Drdy = 1'b1; tick(); Drdy = 1'b0; tick();
    EN = 1'b0;
    repeat (10) tick();
    chk("f_bsy", BSY, 1);
    chk("f_req", cif.core_req, 1);
    EN = 1'b1;
    n = 12;
    while (!Dvld && n < 100) begin tick(); n++; end
    chk("f_lat",  n, 16);
    chk("f_dout", Dout, PT1 + 128'd1);
    EN = 1'b0;
    repeat (3) tick();
    chk("f_dvld_hold", Dvld, 1);
    EN = 1'b1;
    tick();
    chk("f_dvld_drop", Dvld, 0);

    // Reset in the middle of REFRESH
    MODE_LFSR = 1'b1; BATCH = 0;
    Din = mkdin(PT2, 8'h00, 5'h07, 32'hDEAD_BEEF, 1'b1);
    Drdy = 1'b1; tick(); Drdy = 1'b0;
    repeat (4) tick();
    chk("m_bsy", BSY, 1);
    chk("m_req", cif.core_req, 0);
    RSTn = 1'b0;
    #1;
    chk("m_dout", Dout, 0);
    chk("m_bsy_clr", BSY, 0);
    chk("m_rnd", cif.core_rnd, 0);
    chk("m_pt",  cif.core_pt, 0);
    chk("m_key", cif.core_key, 0);
    tick();
    RSTn = 1'b1;
    seen = 0;
    repeat (40) begin tick(); if (Dvld) seen = 1; end
    chk("m_no_dvld", seen, 0);
    chk("m_idle",    BSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
